// File: rtl/spatz_vrf_warb_if.sv
// rtl/spatz_vrf_warb_if.sv - VRF write-arbiter request/grant bundle
interface spatz_vrf_warb_if #(
    parameter int unsigned NrReq   = 3,
    parameter int unsigned NrBanks = 4
);
    localparam int unsigned BW = (NrBanks > 1) ? $clog2(NrBanks) : 1;

    logic [NrReq-1:0]         req_i;
    logic [NrReq-1:0][BW-1:0] bank_i;
    logic [NrReq-1:0]         gnt_o;
    logic [NrReq-1:0]         boost_o;
    logic [15:0]              conflict_cnt_o;

    modport master (
        output req_i, bank_i,
        input  gnt_o, boost_o, conflict_cnt_o
    );

    modport slave (
        input  req_i, bank_i,
        output gnt_o, boost_o, conflict_cnt_o
    );
endinterface

// File: rtl/spatz_vrf_warb.sv
// rtl/spatz_vrf_warb.sv - per-bank VRF write arbiter with starvation boost
// Fixed priority per bank, overridden by requesters denied MaxStall cycles in a row.
module spatz_vrf_warb #(
    parameter int unsigned NrBanks  = 4,
    parameter int unsigned NrReq    = 3,
    parameter int unsigned MaxStall = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    spatz_vrf_warb_if.slave bus
);
    localparam int unsigned BW = (NrBanks > 1) ? $clog2(NrBanks) : 1;
    localparam int unsigned SW = (MaxStall > 0) ? $clog2(MaxStall + 1) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(MaxStall);

    if (MaxStall == 0) begin : g_bad_max_stall
        $error("spatz_vrf_warb: MaxStall must be at least 1");
    end
    if (NrBanks < 2 || (NrBanks & (NrBanks - 1)) != 0) begin : g_bad_nr_banks
        $error("spatz_vrf_warb: NrBanks must be a power of two >= 2");
    end

    logic [SW-1:0]    r_stall [NrReq];
    logic [15:0]      r_conflict_cnt;
    logic [NrReq-1:0] w_boost;
    logic [NrReq-1:0] w_gnt;
    logic [NrReq-1:0] w_denied;

    function automatic logic [NrReq-1:0] lowest_one(input logic [NrReq-1:0] v);
        logic [NrReq-1:0] r;
        r = '0;
        for (int i = NrReq - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        w_boost = '0;
        for (int i = 0; i < NrReq; i++) begin
            w_boost[i] = !rst_i && (r_stall[i] == STALL_MAX);
        end
    end

    // Each bank picks independently; a boosted candidate pre-empts fixed priority.
    always_comb begin
        logic [NrReq-1:0] cand;
        cand  = '0;
        w_gnt = '0;
        for (int b = 0; b < NrBanks; b++) begin
            for (int i = 0; i < NrReq; i++) begin
                cand[i] = bus.req_i[i] && (bus.bank_i[i] == BW'(b));
            end
            if ((cand & w_boost) != '0) begin
                w_gnt = w_gnt | lowest_one(cand & w_boost);
            end else begin
                w_gnt = w_gnt | lowest_one(cand);
            end
        end
        if (rst_i) begin
            w_gnt = '0;
        end
    end

    assign w_denied = rst_i ? '0 : (bus.req_i & ~w_gnt);

    // Bank changes do not reset the counter: only a grant or a withdrawal does.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrReq; i++) begin
                r_stall[i] <= '0;
            end
            r_conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NrReq; i++) begin
                if (w_denied[i]) begin
                    r_stall[i] <= (r_stall[i] == STALL_MAX) ? r_stall[i] : r_stall[i] + SW'(1);
                end else begin
                    r_stall[i] <= '0;
                end
            end
            if ((w_denied != '0) && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign bus.gnt_o          = w_gnt;
    assign bus.boost_o        = w_boost;
    assign bus.conflict_cnt_o = rst_i ? 16'd0 : r_conflict_cnt;
endmodule

// File: tb/tb_spatz_vrf_warb.sv
// tb/tb_spatz_vrf_warb.sv - directed self-checking bench for spatz_vrf_warb
module tb_spatz_vrf_warb;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    spatz_vrf_warb_if #(.NrReq(3), .NrBanks(4)) bus ();

    spatz_vrf_warb #(
        .NrBanks (4),
        .NrReq   (3),
        .MaxStall(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic [2:0] req,
                         input logic [1:0] b0, input logic [1:0] b1, input logic [1:0] b2);
        @(negedge clk);
        rst           = r;
        bus.req_i     = req;
        bus.bank_i[0] = b0;
        bus.bank_i[1] = b1;
        bus.bank_i[2] = b2;
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] gnt, input logic [2:0] boost,
                           input logic [15:0] cnt);
        chk({tag, "_gnt"}, {13'd0, bus.gnt_o}, {13'd0, gnt});
        chk({tag, "_boost"}, {13'd0, bus.boost_o}, {13'd0, boost});
        chk({tag, "_cnt"}, bus.conflict_cnt_o, cnt);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.req_i     = '0;
        bus.bank_i    = '0;

        // Reset held two cycles with everyone fighting for bank 0
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'b111, 2'd0, 2'd0, 2'd0);
            chk_all("reset", 3'b000, 3'b000, 16'd0);
        end
        drive(1'b0, 3'b111, 2'd0, 2'd0, 2'd0);
        chk_all("release", 3'b001, 3'b000, 16'd0);

        // Disjoint banks: everyone granted, no new conflicts
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'b111, 2'd0, 2'd1, 2'd2);
            chk_all("disjoint", 3'b111, 3'b000, 16'd1);
        end
        drive(1'b0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_all("idle1", 3'b000, 3'b000, 16'd1);

        // VFU vs VSLDU on bank 1: period-5 starvation boost
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 3'b101, 2'd1, 2'd1, 2'd1);
            if (k % 5 == 4) chk_all("starve", 3'b100, 3'b100, 16'(1 + k));
            else            chk_all("starve", 3'b001, 3'b000, 16'(1 + k));
        end
        drive(1'b0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_all("idle2", 3'b000, 3'b000, 16'd11);

        // Double boost on bank 3: VLSU first, VSLDU stays boosted and wins next
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 3'b111, 2'd3, 2'd3, 2'd3);
            if (k < 4)       chk_all("dboost", 3'b001, 3'b000, 16'(11 + k));
            else if (k == 4) chk_all("dboost", 3'b010, 3'b110, 16'(11 + k));
            else             chk_all("dboost", 3'b100, 3'b100, 16'(11 + k));
        end
        drive(1'b0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_all("idle3", 3'b000, 3'b000, 16'd17);

        // Withdrawal at stall 3 clears the counter; later bank hop keeps it
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'b101, 2'd0, 2'd0, 2'd0);
            chk_all("wd_pre", 3'b001, 3'b000, 16'(17 + k));
        end
        drive(1'b0, 3'b001, 2'd0, 2'd0, 2'd0);
        chk_all("wd_drop", 3'b001, 3'b000, 16'd20);
        for (int k = 0; k < 5; k++) begin
            if (k < 2) drive(1'b0, 3'b101, 2'd0, 2'd0, 2'd0);
            else       drive(1'b0, 3'b101, 2'd2, 2'd0, 2'd2);
            if (k == 4) chk_all("wd_post", 3'b100, 3'b100, 16'(20 + k));
            else        chk_all("wd_post", 3'b001, 3'b000, 16'(20 + k));
        end
        drive(1'b0, 3'b000, 2'd0, 2'd0, 2'd0);
        chk_all("idle4", 3'b000, 3'b000, 16'd25);

        // Saturation: 65540 conflicting cycles push 25 + 65540 past 16'hFFFF
        for (int k = 0; k < 65540; k++) begin
            drive(1'b0, 3'b101, 2'd0, 2'd0, 2'd0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 3'b101, 2'd0, 2'd0, 2'd0);
            chk_all("sat", 3'b001, 3'b000, 16'hFFFF);
        end

        // Reset lands where VSLDU would be boosted; boost must be discarded
        drive(1'b1, 3'b101, 2'd0, 2'd0, 2'd0);
        chk_all("midrst", 3'b000, 3'b000, 16'd0);
        drive(1'b0, 3'b101, 2'd0, 2'd0, 2'd0);
        chk_all("postrst0", 3'b001, 3'b000, 16'd0);
        drive(1'b0, 3'b101, 2'd0, 2'd0, 2'd0);
        chk_all("postrst1", 3'b001, 3'b000, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spatz_vrf_warb.md
SPATZ_VRF_WARB -- requirements
Module: spatz_vrf_warb

Interface
REQ-001 SHALL have parameter NrBanks, default 4, meaning the number of VRF banks (power of two, at least 2).
REQ-002 SHALL have parameter NrReq, default 3, meaning the number of write requesters (index 0 VFU, 1 VLSU, 2 VSLDU).
REQ-003 SHALL have parameter MaxStall, default 4, meaning the number of consecutive denied cycles that boosts a requester; MaxStall = 0 SHALL raise an elaboration error.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_i  input  NrReq  per-requester write request for the current cycle.
REQ-007 SHALL have port bank_i  input  NrReq x clog2(NrBanks)  target bank per requester.
REQ-008 SHALL have port gnt_o  output  NrReq  per-requester write grant, same cycle.
REQ-009 SHALL have port boost_o  output  NrReq  requester is currently boosted.
REQ-010 SHALL have port conflict_cnt_o  output  16  saturating count of cycles with at least one denied request.

Function
REQ-011 SHALL, per bank, form the candidate set: requesters with req_i set and bank_i equal to that bank.
REQ-012 SHALL grant the lowest-index boosted candidate when the candidate set contains at least one boosted requester.
REQ-013 SHALL otherwise grant the lowest-index candidate (fixed priority VFU > VLSU > VSLDU).
REQ-014 SHALL assert at most one gnt_o per bank per cycle, and gnt_o[i] only when req_i[i] is set.
REQ-015 SHALL drive gnt_o combinationally from req_i, bank_i and registered state, with zero-cycle latency.
REQ-016 SHALL keep a per-requester stall counter of width clog2(MaxStall+1).
REQ-017 SHALL, for the stall counter, increment by 1 saturating at MaxStall when req_i set and gnt_o clear.
REQ-018 SHALL, for the stall counter, clear to 0 when gnt_o is set or req_i is clear.
REQ-019 SHALL derive boost_o[i] as stall counter[i] equal to MaxStall, from registered state only.
REQ-020 SHALL keep a boosted requester boosted, counter held at MaxStall, while it remains requesting and denied (loses to a lower-index boosted requester).
REQ-021 SHALL increment conflict_cnt_o by 1 in every cycle where any requester has req_i set and gnt_o clear; saturate at 16'hFFFF.
REQ-022 SHALL treat a requester changing bank_i while stalled as the same request: the counter is not cleared.
REQ-023 SHALL bound starvation: a continuously requesting requester is granted within MaxStall+NrReq cycles.

Reset
REQ-024 SHALL, while rst_i is high, force gnt_o = 0, boost_o = 0 and conflict_cnt_o = 0, ignoring req_i.
REQ-025 SHALL, on a clock edge with rst_i high, clear all stall counters and conflict_cnt_o.
REQ-026 SHALL, on reset asserted mid-operation, discard boosted state; arbitration restarts in fixed priority in the first cycle after rst_i falls.

Verification
REQ-027 SHALL cover reset: rst_i high 2 cycles with req_i = 3'b111, all targeting bank 0 -> gnt_o = 0 and conflict_cnt_o = 0 throughout; first cycle after release gnt_o = 3'b001.
REQ-028 SHALL cover the disjoint case: req_i = 3'b111 with bank_i = {2,1,0} -> gnt_o = 3'b111 every cycle; conflict_cnt_o unchanged.
REQ-029 SHALL cover starvation boost: VFU and VSLDU continuously on bank 1, MaxStall = 4:
- cycles 0-3 -> gnt_o = 3'b001.
- cycle 4 -> boost_o[2] = 1, gnt_o = 3'b100.
- cycle 5 -> gnt_o = 3'b001.
- pattern repeats with period 5; conflict_cnt_o = 10 after 10 cycles.
REQ-030 SHALL cover the double boost: VLSU and VSLDU both boosted on bank 3 -> VLSU granted; VSLDU stays boosted and is granted next cycle.
REQ-031 SHALL cover request withdrawal: VSLDU stall counter at 3 and req_i[2] drops for 1 cycle -> counter = 0, boost_o[2] = 0; boost is reached only after 4 further denied cycles.
REQ-032 SHALL cover saturation: force a conflict for 65540 cycles -> conflict_cnt_o = 16'hFFFF and holds.
